br_redirect_ctrl: RTL and testbench
===================================

BR_REDIRECT_CTRL -- requirements
Module: br_redirect_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: EX_br_req  in  1  raw mispredict from the EX branch unit (A or B slot, before stall suppression).
REQ-004 SHALL have: EX_br_a  in  1  mispredict belongs to slot A.
REQ-005 SHALL have: EX_pc_br  in  32  corrected fetch address.
REQ-006 SHALL have: stall_dcache  in  1; stall_div  in  1  pipeline stall sources.
REQ-007 SHALL have: stall_dcache_buf  out  1; stall_div_buf  out  1  stall sources delayed one cycle.
REQ-008 SHALL have: redirect_ready  in  1  fetch stage accepts redirect (low during icache miss).
REQ-009 SHALL have: redirect_valid  out  1; redirect_pc  out  32  redirect request to fetch.
REQ-010 SHALL have: flush_ID  out  1; flush_EX_b  out  1  squash ID stage / squash EX slot B.
REQ-011 SHALL have: mispredict_cnt  out  32  accepted-mispredict performance counter.

Function
REQ-012 stall_dcache_buf / stall_div_buf SHALL equal stall_dcache / stall_div registered one cycle.
REQ-013 lock flag SHALL set on accept; SHALL clear on the first cycle with stall_dcache=0 and stall_div=0 (pipeline advances); set and clear in same cycle -> stays set.
REQ-014 accept SHALL be combinational: EX_br_req & ~lock & ~stall_dcache_buf & ~stall_div_buf & state==BR_IDLE.
REQ-015 FSM states SHALL be BR_IDLE, BR_REDIRECT; BR_IDLE -> BR_REDIRECT on accept; BR_REDIRECT -> BR_IDLE when redirect_valid & redirect_ready.
REQ-016 redirect_pc SHALL latch EX_pc_br on accept; redirect_valid SHALL be 1 exactly while state==BR_REDIRECT (one-cycle latency from accept).
REQ-017 redirect_pc SHALL stay stable while redirect_valid=1 and redirect_ready=0.
REQ-018 flush_ID SHALL be 1 in the accept cycle and every cycle in BR_REDIRECT (squash wrong-path fetches).
REQ-019 flush_EX_b SHALL be 1 only in the accept cycle and only when EX_br_a=1.
REQ-020 EX_br_req while in BR_REDIRECT or while lock=1 SHALL be ignored (no accept, no counter change).
REQ-021 mispredict_cnt SHALL increment by 1 per accept, saturating at 32'hFFFF_FFFF.
REQ-022 accept coinciding with rising stall_dcache or stall_div SHALL still accept (buf is still 0); the following stalled cycles SHALL NOT re-accept.

Reset
REQ-023 on rst=1 at a clock edge: state=BR_IDLE, lock=0, both stall bufs=0, redirect_valid=0, redirect_pc=0, mispredict_cnt=0; flush outputs 0 while rst=1.
REQ-024 rst in BR_REDIRECT SHALL abandon the pending redirect with no further redirect_valid.

Structure
REQ-025 the shared package SHALL hold the br_ctrl_state_t enum (BR_IDLE, BR_REDIRECT) and the counter width constant MISPRED_CNT_W=32.
REQ-026 the saturating counter SHALL be one sub-module, sat_counter, parameterised by width; all else is flat.

Verification
REQ-027 EX_br_req=1, EX_br_a=1, EX_pc_br=32'h1C00_0040, redirect_ready=1 -> same cycle flush_ID=1, flush_EX_b=1; next cycle redirect_valid=1, redirect_pc=32'h1C00_0040; cnt=1.
REQ-028 as REQ-027 with redirect_ready=0 for 3 cycles -> redirect_valid=1 and flush_ID=1 for 4 cycles, pc held; return to BR_IDLE after handshake.
REQ-029 EX_br_req held 5 cycles with stall_dcache=1 on cycles 1-4 -> exactly one accept, cnt=1, stall_dcache_buf=1 on cycles 2-5.
REQ-030 EX_br_req=1, EX_br_a=0, EX_pc_br=32'h1C00_0100 -> flush_EX_b=0, flush_ID=1, redirect_pc=32'h1C00_0100.
REQ-031 rst=1 during BR_REDIRECT -> next cycle redirect_valid=0, cnt=0, state BR_IDLE; preload cnt=32'hFFFF_FFFF, one accept -> cnt stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/br_redirect_ctrl_pkg.sv
// Shared types and widths for the branch-redirect controller.
package br_redirect_ctrl_pkg;

  localparam int unsigned MISPRED_CNT_W = 32;
  localparam int unsigned PC_W          = 32;

  typedef enum logic [0:0] {
    BR_IDLE     = 1'b0,
    BR_REDIRECT = 1'b1
  } br_ctrl_state_t;

endpackage

// File: rtl/br_redirect_ctrl_sat_counter.sv
// Saturating up-counter: increments by one per inc pulse and sticks at all-ones.
// Ports: clk, rst (sync, active-high), inc (count enable), count (current value).
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/br_redirect_ctrl.sv
// Branch mispredict redirect controller: accepts one EX mispredict per pipeline
// advance, flushes the wrong path, and holds a redirect to fetch until taken.
// Ports: clk/rst; EX_br_req/EX_br_a/EX_pc_br mispredict from EX; stall_dcache,
//        stall_div in and their one-cycle-delayed copies out; redirect_valid,
//        redirect_pc, redirect_ready handshake to fetch; flush_ID, flush_EX_b
//        squash controls; mispredict_cnt accepted-mispredict counter.
module br_redirect_ctrl
  import br_redirect_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     EX_br_req,
  input  logic                     EX_br_a,
  input  logic [PC_W-1:0]          EX_pc_br,
  input  logic                     stall_dcache,
  input  logic                     stall_div,
  output logic                     stall_dcache_buf,
  output logic                     stall_div_buf,
  input  logic                     redirect_ready,
  output logic                     redirect_valid,
  output logic [PC_W-1:0]          redirect_pc,
  output logic                     flush_ID,
  output logic                     flush_EX_b,
  output logic [MISPRED_CNT_W-1:0] mispredict_cnt
);

  br_ctrl_state_t state_q, state_d;
  logic           lock;
  logic           accept_c;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, accept and flush decode
  always_comb begin
    state_d        = state_q;
    accept_c       = 1'b0;
    flush_ID       = 1'b0;
    flush_EX_b     = 1'b0;
    redirect_valid = 1'b0;
    case (state_q)
      BR_IDLE: begin
        // Buffered stalls block re-accepting the same branch while EX is frozen
        accept_c   = EX_br_req & ~lock & ~stall_dcache_buf & ~stall_div_buf & ~rst;
        flush_ID   = accept_c;
        flush_EX_b = accept_c & EX_br_a;
        if (accept_c) begin
          state_d = BR_REDIRECT;
        end
      end
      BR_REDIRECT: begin
        redirect_valid = 1'b1;
        flush_ID       = ~rst;
        if (redirect_ready) begin
          state_d = BR_IDLE;
        end
      end
      default: state_d = BR_IDLE;
    endcase
  end

  // Stall delay, lock and captured redirect target
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_dcache_buf <= 1'b0;
      stall_div_buf    <= 1'b0;
      lock             <= 1'b0;
      redirect_pc      <= '0;
    end else begin
      stall_dcache_buf <= stall_dcache;
      stall_div_buf    <= stall_div;
      // Set wins over clear so an accept in an advancing cycle still locks
      if (accept_c) begin
        lock        <= 1'b1;
        redirect_pc <= EX_pc_br;
      end else if (!stall_dcache && !stall_div) begin
        lock <= 1'b0;
      end
    end
  end

  sat_counter #(
    .WIDTH(MISPRED_CNT_W)
  ) u_mispred_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (accept_c),
    .count(mispredict_cnt)
  );

endmodule

// File: tb/tb_br_redirect_ctrl.sv
// Self-checking bench for br_redirect_ctrl: reference model plus a scoreboard of
// expected redirect targets popped at each fetch handshake.
module tb_br_redirect_ctrl;
  import br_redirect_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_br_req, EX_br_a;
  logic [31:0] EX_pc_br;
  logic        stall_dcache, stall_div;
  logic        stall_dcache_buf, stall_div_buf;
  logic        redirect_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_ID, flush_EX_b;
  logic [31:0] mispredict_cnt;

  logic        s_rst, s_inc;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  br_redirect_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .EX_br_req       (EX_br_req),
    .EX_br_a         (EX_br_a),
    .EX_pc_br        (EX_pc_br),
    .stall_dcache    (stall_dcache),
    .stall_div       (stall_div),
    .stall_dcache_buf(stall_dcache_buf),
    .stall_div_buf   (stall_div_buf),
    .redirect_ready  (redirect_ready),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .flush_ID        (flush_ID),
    .flush_EX_b      (flush_EX_b),
    .mispredict_cnt  (mispredict_cnt)
  );

  sat_counter #(.WIDTH(4)) u_sat (
    .clk  (clk),
    .rst  (s_rst),
    .inc  (s_inc),
    .count(s_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic        m_state, m_lock, m_sdb, m_svb;
  logic [31:0] m_pc, m_cnt;
  logic [31:0] exp_q[$];
  int          valid_cycles;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, check at posedge+4, update model, return at next posedge+1
  task automatic cyc(input logic r, input logic req, input logic a, input logic [31:0] pc,
                     input logic sd, input logic sv, input logic rdy);
    logic        acc;
    logic [31:0] exp_pc;
    rst = r; EX_br_req = req; EX_br_a = a; EX_pc_br = pc;
    stall_dcache = sd; stall_div = sv; redirect_ready = rdy;
    #3;
    acc = !r && req && !m_lock && !m_sdb && !m_svb && !m_state;
    check_eq("flush_ID", 32'(flush_ID), 32'(acc || (m_state && !r)));
    check_eq("flush_EX_b", 32'(flush_EX_b), 32'(acc && a));
    check_eq("redirect_valid", 32'(redirect_valid), 32'(m_state));
    check_eq("stall_dcache_buf", 32'(stall_dcache_buf), 32'(m_sdb));
    check_eq("stall_div_buf", 32'(stall_div_buf), 32'(m_svb));
    check_eq("mispredict_cnt", mispredict_cnt, m_cnt);
    if (m_state) begin
      valid_cycles++;
      check_eq("redirect_pc_hold", redirect_pc, m_pc);
    end
    if (redirect_valid && rdy && !r) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected_redirect", 32'(redirect_valid), 32'(0));
      end else begin
        exp_pc = exp_q.pop_front();
        check_eq("sb_redirect_pc", redirect_pc, exp_pc);
      end
    end
    if (r) begin
      m_state = 1'b0; m_lock = 1'b0; m_sdb = 1'b0; m_svb = 1'b0;
      m_pc = '0; m_cnt = '0;
      exp_q.delete();
    end else begin
      if (acc) begin
        exp_q.push_back(pc);
        m_pc = pc;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        m_state = 1'b1;
        m_lock  = 1'b1;
      end else begin
        if (m_state && rdy) m_state = 1'b0;
        if (!sd && !sv) m_lock = 1'b0;
      end
      m_sdb = sd;
      m_svb = sv;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] cnt_before;
    rst = 1'b1; EX_br_req = 1'b1; EX_br_a = 1'b1; EX_pc_br = 32'hDEAD_BEE0;
    stall_dcache = 1'b0; stall_div = 1'b0; redirect_ready = 1'b1;
    s_rst = 1'b1; s_inc = 1'b0;
    m_state = 1'b0; m_lock = 1'b0; m_sdb = 1'b0; m_svb = 1'b0;
    m_pc = '0; m_cnt = '0; valid_cycles = 0;
    repeat (2) @(posedge clk);
    #3;
    // Reset state, with a request pending that must not flush
    check_eq("rst_flush_ID", 32'(flush_ID), 32'(0));
    check_eq("rst_flush_EX_b", 32'(flush_EX_b), 32'(0));
    check_eq("rst_redirect_valid", 32'(redirect_valid), 32'(0));
    check_eq("rst_redirect_pc", redirect_pc, 32'h0);
    check_eq("rst_cnt", mispredict_cnt, 32'h0);
    check_eq("rst_stall_bufs", 32'({stall_dcache_buf, stall_div_buf}), 32'(0));
    @(posedge clk);
    #1;
    s_rst = 1'b0;

    // Slot-A mispredict, fetch ready
    cyc(1'b0, 1'b1, 1'b1, 32'h1C00_0040, 1'b0, 1'b0, 1'b1);
    check_eq("a_redirect_valid", 32'(redirect_valid), 32'(1));
    check_eq("a_redirect_pc", redirect_pc, 32'h1C00_0040);
    check_eq("a_cnt", mispredict_cnt, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("a_back_idle", 32'(redirect_valid), 32'(0));

    // Fetch stalls the redirect for three cycles
    valid_cycles = 0;
    cyc(1'b0, 1'b1, 1'b1, 32'h1C00_0080, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_eq("held_valid_cycles", 32'(valid_cycles), 32'd4);
    check_eq("held_back_idle", 32'(redirect_valid), 32'(0));
    check_eq("held_cnt", mispredict_cnt, 32'd2);

    // Request held across a dcache stall: one accept only
    cnt_before = mispredict_cnt;
    for (int i = 1; i <= 5; i++) cyc(1'b0, 1'b1, 1'b1, 32'h1C00_00C0, (i <= 4), 1'b0, 1'b1);
    check_eq("dstall_cnt", mispredict_cnt, cnt_before + 32'd1);
    check_eq("dstall_buf_drop", 32'(stall_dcache_buf), 32'(0));
    idle(1);

    // Slot-B mispredict does not kill EX slot B
    cyc(1'b0, 1'b1, 1'b0, 32'h1C00_0100, 1'b0, 1'b0, 1'b1);
    check_eq("b_redirect_pc", redirect_pc, 32'h1C00_0100);
    idle(2);

    // Requests during a pending redirect are ignored
    cnt_before = mispredict_cnt;
    cyc(1'b0, 1'b1, 1'b1, 32'h1C00_0200, 1'b0, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 1'b1, 1'b1, 32'h1C00_0300, 1'b0, 1'b0, 1'b0);
    check_eq("ign_pc", redirect_pc, 32'h1C00_0200);
    check_eq("ign_cnt", mispredict_cnt, cnt_before + 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    idle(2);

    // Request held across a divider stall
    cnt_before = mispredict_cnt;
    for (int i = 1; i <= 4; i++) cyc(1'b0, 1'b1, 1'b0, 32'h1C00_0400, (i == 3), (i <= 2), 1'b1);
    check_eq("divstall_cnt", mispredict_cnt, cnt_before + 32'd1);
    idle(2);

    // Reset abandons a pending redirect
    cyc(1'b0, 1'b1, 1'b1, 32'h1C00_0500, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    check_eq("rstpend_valid", 32'(redirect_valid), 32'(0));
    check_eq("rstpend_cnt", mispredict_cnt, 32'h0);
    idle(3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 2) != 0));
    end
    idle(3);
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);

    // Saturation on a narrow instance of the counter
    check_eq("sat_start", 32'(s_cnt), 32'd0);
    s_inc = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("sat_three", 32'(s_cnt), 32'd3);
    repeat (20) @(posedge clk);
    #1;
    check_eq("sat_hold", 32'(s_cnt), 32'd15);
    s_inc = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
